fetch_stage: RTL and testbench

//   IF stage of the 5-stage MIPS pipeline: owns the PC and drives the instruction-memory address.

---
 rtl/fetch_stage.sv | 135 +++++++++++++
 tb/tb_fetch_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: owns the PC, drives the instruction-memory address,
// and registers the fetched word into IF/ID. Optional redirect alignment check: IF_ALIGN_CHECK_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic [31:0] iaddr,
  input  logic [31:0] idata,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        halted,
  output logic        fetch_exc
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] pc_seq;
  logic [31:0] redirect_tgt;
  logic [31:0] instr_nxt;
  logic [31:0] pc4_nxt;
  logic        valid_nxt;
  logic        misaligned;
  logic        exc_set;

  assign pc_seq = pc + PC_INC;
  assign iaddr  = pc;
  assign halted = (state == HALT);

`ifdef IF_ALIGN_CHECK_EN
  assign misaligned   = redirect && (redirect_pc[1:0] != 2'b00);
  assign redirect_tgt = redirect_pc;
`else
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_pc[1:0];
  assign misaligned      = 1'b0;
  assign redirect_tgt    = {redirect_pc[31:2], 2'b00};
`endif

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = ifid_instr;
    pc4_nxt   = ifid_pc4;
    valid_nxt = ifid_valid;
    exc_set   = 1'b0;
    unique case (state)
      BOOT: begin
        // Guard cycle after reset release: hold RESET_PC, nothing valid yet.
        state_nxt = RUN;
        valid_nxt = 1'b0;
      end
      RUN: begin
        if (halt_req) begin
          state_nxt = HALT;
          valid_nxt = 1'b0;
        end else if (misaligned) begin
          state_nxt = HALT;
          valid_nxt = 1'b0;
          exc_set   = 1'b1;
        end else begin
          // Redirect wins over stall for the PC; the delay-slot word is still captured below.
          if (redirect)    pc_nxt = redirect_tgt;
          else if (!stall) pc_nxt = pc_seq;

          if (flush) begin
            valid_nxt = 1'b0;
            instr_nxt = 32'h0;
            pc4_nxt   = 32'h0;
          end else if (!stall) begin
            valid_nxt = 1'b1;
            instr_nxt = idata;
            pc4_nxt   = pc_seq;
          end
        end
      end
      HALT: begin
        valid_nxt = 1'b0;
      end
      default: begin
        state_nxt = BOOT;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= BOOT;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc         <= RESET_PC;
      ifid_instr <= 32'h0;
      ifid_pc4   <= 32'h0;
      ifid_valid <= 1'b0;
    end else begin
      pc         <= pc_nxt;
      ifid_instr <= instr_nxt;
      ifid_pc4   <= pc4_nxt;
      ifid_valid <= valid_nxt;
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  // Sticky until reset; a misaligned target also parks the FSM in HALT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         fetch_exc <= 1'b0;
    else if (exc_set) fetch_exc <= 1'b1;
  end
`else
  logic unused_exc_set;
  assign unused_exc_set = exc_set;
  assign fetch_exc      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: boot, stall, redirect/delay slot, flush,
// halt, async reset, PC wrap and redirect alignment (both IF_ALIGN_CHECK_EN builds).
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        halted;
  logic        fetch_exc;

  logic [31:0] mem [64];
  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt_req   (halt_req),
    .iaddr      (iaddr),
    .idata      (idata),
    .ifid_instr (ifid_instr),
    .ifid_pc4   (ifid_pc4),
    .ifid_valid (ifid_valid),
    .halted     (halted),
    .fetch_exc  (fetch_exc)
  );

  // Zero-latency instruction memory.
  assign idata = mem[iaddr[7:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h2400_0000 | i;
    mem[0] = 32'h3c18_0007;
    mem[1] = 32'h3c19_0008;

    rst = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; halt_req = 1'b0;
    step();
    check("rst_iaddr", iaddr, 32'h0);
    check("rst_valid", ifid_valid, 0);
    check("rst_instr", ifid_instr, 32'h0);
    check("rst_pc4", ifid_pc4, 32'h0);
    check("rst_halted", halted, 0);
    check("rst_exc", fetch_exc, 0);
    rst = 1'b1;

    // Boot cycle then sequential fetch.
    step();
    check("boot_iaddr", iaddr, 32'h0);
    check("boot_valid", ifid_valid, 0);
    step();
    check("seq1_instr", ifid_instr, 32'h3c18_0007);
    check("seq1_pc4", ifid_pc4, 32'h4);
    check("seq1_valid", ifid_valid, 1);
    check("seq1_iaddr", iaddr, 32'h4);
    step();
    check("seq2_instr", ifid_instr, 32'h3c19_0008);
    check("seq2_pc4", ifid_pc4, 32'h8);
    step();
    check("seq3_instr", ifid_instr, 32'h2400_0002);
    step();
    check("seq4_iaddr", iaddr, 32'h10);
    check("seq4_pc4", ifid_pc4, 32'h10);

    // Stall three cycles at pc=0x10.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_iaddr", iaddr, 32'h10);
      check("stall_instr", ifid_instr, 32'h2400_0003);
      check("stall_pc4", ifid_pc4, 32'h10);
      check("stall_valid", ifid_valid, 1);
    end
    stall = 1'b0;
    step();
    check("unstall_iaddr", iaddr, 32'h14);
    check("unstall_instr", ifid_instr, 32'h2400_0004);
    check("unstall_pc4", ifid_pc4, 32'h14);

    for (int i = 0; i < 8; i++) step();
    check("pre_redir_iaddr", iaddr, 32'h34);

    // Redirect with delay slot captured.
    redirect = 1'b1; redirect_pc = 32'h64;
    step();
    redirect = 1'b0;
    check("slot_instr", ifid_instr, 32'h2400_000d);
    check("slot_pc4", ifid_pc4, 32'h38);
    check("slot_valid", ifid_valid, 1);
    check("redir_iaddr", iaddr, 32'h64);

    // Flush beats stall; then flush alone.
    flush = 1'b1; stall = 1'b1;
    step();
    check("flush_stall_valid", ifid_valid, 0);
    check("flush_stall_iaddr", iaddr, 32'h64);
    stall = 1'b0;
    step();
    check("flush_valid", ifid_valid, 0);
    check("flush_iaddr", iaddr, 32'h68);
    check("flush_instr", ifid_instr, 32'h0);
    flush = 1'b0;
    step();
    check("post_flush_instr", ifid_instr, 32'h2400_001a);
    check("post_flush_pc4", ifid_pc4, 32'h6c);
    check("post_flush_iaddr", iaddr, 32'h6c);

    // Redirect + stall: pc moves, IF/ID holds.
    redirect = 1'b1; redirect_pc = 32'h50; stall = 1'b1;
    step();
    redirect = 1'b0; stall = 1'b0;
    check("rs_iaddr", iaddr, 32'h50);
    check("rs_instr", ifid_instr, 32'h2400_001a);
    check("rs_pc4", ifid_pc4, 32'h6c);
    check("rs_valid", ifid_valid, 1);
    step();
    check("rs_next_instr", ifid_instr, 32'h2400_0014);
    step();
    step();
    check("pre_halt_iaddr", iaddr, 32'h5c);

    // Halt at 0x5C; redirect is ignored while halted.
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    check("halt_halted", halted, 1);
    check("halt_valid", ifid_valid, 0);
    check("halt_instr", ifid_instr, 32'h2400_0016);
    redirect = 1'b1; redirect_pc = 32'h80;
    for (int i = 0; i < 10; i++) begin
      step();
      check("halt_iaddr", iaddr, 32'h5c);
      check("halt_hold_valid", ifid_valid, 0);
      check("halt_hold", halted, 1);
    end
    redirect = 1'b0;

    // Asynchronous reset mid-cycle.
    #2 rst = 1'b0;
    #1;
    check("arst_iaddr", iaddr, 32'h0);
    check("arst_halted", halted, 0);
    check("arst_valid", ifid_valid, 0);
    check("arst_instr", ifid_instr, 32'h0);
    step();
    rst = 1'b1;
    step();
    check("reboot_iaddr", iaddr, 32'h0);
    check("reboot_valid", ifid_valid, 0);
    step();
    check("refetch_instr", ifid_instr, 32'h3c18_0007);
    check("refetch_iaddr", iaddr, 32'h4);

    // PC wrap at the top of the address space.
    redirect = 1'b1; redirect_pc = 32'hffff_fffc;
    step();
    redirect = 1'b0;
    check("wrap_top_iaddr", iaddr, 32'hffff_fffc);
    step();
    check("wrap_iaddr", iaddr, 32'h0);
    check("wrap_pc4", ifid_pc4, 32'h0);
    check("wrap_instr", ifid_instr, 32'h2400_003f);

    // Misaligned redirect target.
    redirect = 1'b1; redirect_pc = 32'h62;
    step();
    redirect = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
    check("align_iaddr", iaddr, 32'h0);
    check("align_exc", fetch_exc, 1);
    check("align_halted", halted, 1);
    check("align_valid", ifid_valid, 0);
    step();
    check("align_exc_sticky", fetch_exc, 1);
`else
    check("align_iaddr", iaddr, 32'h60);
    check("align_exc", fetch_exc, 0);
    check("align_halted", halted, 0);
    check("align_instr", ifid_instr, 32'h3c18_0007);
    check("align_pc4", ifid_pc4, 32'h4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
